// File: rtl/key_exp_controller.sv
// SM4 key-schedule sequencer. It runs one expansion round per cycle and streams one 32-bit round key per cycle.
// Define KEY_EXP_STORE_EN to add a 32-entry round-key table with a registered random-access read port.

module one_round_for_key_exp (
  input  logic [127:0] data_in,
  input  logic [4:0]   count_round_in,
  input  logic [31:0]  ck_parameter_in,
  output logic [127:0] result_out
);
  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic [127:0] k;
  logic [31:0]  t, s, l;

  always_comb begin
    k = (count_round_in == 5'd0) ? (data_in ^ FK) : data_in;
    t = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_parameter_in;
    s = '0;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = SBOX[t[8*b +: 8]];
    l = s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
    result_out = {k[95:0], k[127:96] ^ l};
  end
endmodule

module key_exp_controller #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic         abort_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         rk_valid_out,
  output logic [4:0]   rk_idx_out,
  output logic [31:0]  rk_out,
`ifdef KEY_EXP_STORE_EN
  input  logic [4:0]   rk_rd_addr_in,
  output logic [31:0]  rk_rd_data_out,
  output logic         rk_table_valid_out,
`endif
  output logic         done_out
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [127:0] key_reg_q, key_reg_d;
  logic [4:0]   rnd_q, rnd_d;
  logic         rk_valid_q, rk_valid_d;
  logic [4:0]   rk_idx_q, rk_idx_d;
  logic [31:0]  rk_q, rk_d;
  logic         done_q, done_d;
  logic [31:0]  ck;
  logic [127:0] round_result;

  // Byte j of CK[i] is (4i+j)*7 with 8-bit wrap.
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++)
      ck[31-8*j -: 8] = ({1'b0, rnd_q, 2'b00} + 8'(j)) * 8'd7;
  end

  one_round_for_key_exp u_round (
    .data_in         (key_reg_q),
    .count_round_in  (rnd_q),
    .ck_parameter_in (ck),
    .result_out      (round_result)
  );

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    key_reg_d  = key_reg_q;
    rnd_d      = rnd_q;
    rk_valid_d = 1'b0;
    rk_idx_d   = rk_idx_q;
    rk_d       = rk_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = RUN;
          key_reg_d = key_in;
          rnd_d     = '0;
        end
      end
      RUN: begin
        if (abort_in) begin
          state_d = IDLE;
        end else begin
          key_reg_d  = round_result;
          rk_d       = round_result[31:0];
          rk_idx_d   = rnd_q;
          rk_valid_d = 1'b1;
          rnd_d      = rnd_q + 5'd1;
          if (rnd_q == LAST_RND) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_reg_q  <= '0;
      rnd_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_reg_q  <= key_reg_d;
      rnd_q      <= rnd_d;
      rk_valid_q <= rk_valid_d;
      rk_idx_q   <= rk_idx_d;
      rk_q       <= rk_d;
      done_q     <= done_d;
    end
  end

  assign busy_out     = (state_q == RUN);
  assign rk_valid_out = rk_valid_q;
  assign rk_idx_out   = rk_idx_q;
  assign rk_out       = rk_q;
  assign done_out     = done_q;

`ifdef KEY_EXP_STORE_EN
  logic [31:0] rk_table_q [32];
  logic [31:0] rd_data_q, rd_data_d;
  logic        table_valid_q, table_valid_d;

  always_comb begin
    rd_data_d     = rk_table_q[rk_rd_addr_in];
    table_valid_d = table_valid_q;
    if (state_q == IDLE && start_in)      table_valid_d = 1'b0;
    else if (state_q == RUN && abort_in)  table_valid_d = 1'b0;
    else if (done_d)                      table_valid_d = 1'b1;
  end

  // NOTE: the key table has no reset; consumers gate reads on rk_table_valid_out.
  always_ff @(posedge clk) begin
    if (rk_valid_d) rk_table_q[rnd_q] <= round_result[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q     <= '0;
      table_valid_q <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      table_valid_q <= table_valid_d;
    end
  end

  assign rk_rd_data_out     = rd_data_q;
  assign rk_table_valid_out = table_valid_q;
`endif
endmodule

// File: doc/key_exp_controller.md
# key_exp_controller

Sequencer for the SM4 key schedule. Accepts a 128-bit master key, drives the single-round key-expansion datapath (`one_round_for_key_exp`, instantiated inside) for 32 consecutive cycles, generates each round's CK constant on the fly, and streams out one 32-bit round key per cycle. It sits between the key-load interface and the cipher core's round-key consumer, optionally retaining the full key table for random-access reads.

## Interface
- `ROUNDS`, 32: rounds per expansion. Legal values are 1..32. Only 32 is used in product builds; smaller values exist for reduced-round test builds.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_in` in 1: request an expansion. Sampled only in IDLE.
- `abort_in` in 1: cancel a running expansion.
- `key_in` in 128: master key MK0..MK3. MK0 is in [127:96]. Sampled in the cycle `start_in` is accepted.
- `busy_out` out 1: expansion in progress.
- `rk_valid_out` out 1: `rk_out` and `rk_idx_out` hold a new round key this cycle.
- `rk_idx_out` out 5: round index of `rk_out`, from 0 to ROUNDS-1.
- `rk_out` out 32: round key rk[i].
- `done_out` out 1: one-cycle pulse coincident with the last `rk_valid_out`.
- Present only under `KEY_EXP_STORE_EN`:
  - `rk_rd_addr_in` in 5
  - `rk_rd_data_out` out 32
  - `rk_table_valid_out` out 1

## Operation
- **States.** The FSM has two states, IDLE and RUN.
  - IDLE → RUN when `start_in`=1.
  - RUN → IDLE when the round counter reaches ROUNDS-1, or when `abort_in`=1.
- **Start accept (in IDLE).**
  - `state_reg` ← `key_in`.
  - Round counter `rnd` ← 0.
  - `busy_out` ← 1.
  - `abort_in` is ignored in IDLE, so a simultaneous start+abort in IDLE starts a run.
  - `start_in` is ignored in RUN.
- **Each RUN cycle.** The datapath is driven with:
  - `data_in` = `state_reg`.
  - `count_round_in` = `rnd`. The datapath applies the FK XOR itself when `rnd`=0.
  - `ck_parameter_in` = CK[`rnd`].
- **At the edge ending each RUN cycle.**
  - `state_reg` ← `result_out`.
  - `rk_out` ← `result_out[31:0]`.
  - `rk_idx_out` ← `rnd`.
  - `rk_valid_out` ← 1.
  - `rnd` ← `rnd`+1.
- **CK generation.** No ROM is used. Byte j (j=0..3, j=0 is the MSB) of CK[i] is ((4·i+j)·7) mod 256, computed in 8-bit arithmetic with wrap.
  - CK[0] = 00070e15.
  - CK[1] = 1c232a31.
  - CK[31] = 646b7279.
- **Last round** (`rnd`=ROUNDS-1): at the same edge, `done_out` ← 1, `busy_out` ← 0, and the FSM goes to IDLE.
- **Abort (in RUN).** At the next edge the FSM goes to IDLE.
  - `busy_out` ← 0 and `rk_valid_out` ← 0.
  - No `done_out` is issued.
  - `state_reg` and `rnd` are don't-care.
  - Abort takes priority over last-round completion in the same cycle.
- **Reset** (any state, including mid-run). At the next edge:
  - The FSM goes to IDLE.
  - `busy_out`, `rk_valid_out`, `done_out` = 0.
  - `rk_out`, `rk_idx_out` = 0.
  - `rk_table_valid_out` = 0 and `rk_rd_data_out` = 0.

## Timing
- `start_in` accepted at edge E0 → rk[i] is valid in the cycle after edge E(i+1).
- rk[ROUNDS-1] and `done_out` are valid in the cycle after edge E(ROUNDS).
- `busy_out` is high in cycles E0..E(ROUNDS-1).
- Latency from start to first key is 1 cycle. Throughput is 1 key per cycle.
- `rk_valid_out` has no backpressure, so consumers must accept every key.
- `start_in` in the `done_out` cycle is accepted, since the FSM is already in IDLE. A new run therefore starts with zero bubble.
- `rk_valid_out` and `done_out` are registered pulses. Each is held for exactly one cycle per event.

## Configuration
- **`KEY_EXP_STORE_EN` defined.**
  - Adds a 32×32 register table written at index `rnd` with each `rk_out`.
  - The read port is registered: `rk_rd_data_out` = table[`rk_rd_addr_in`] one cycle after the address is presented.
  - `rk_table_valid_out` is set with `done_out`, and cleared on start accept, abort, or reset.
  - Reads while the table is invalid return the stale contents. Consumers must gate on `rk_table_valid_out`.
- **`KEY_EXP_STORE_EN` undefined.** The three ports and the table are absent. Only the streaming output exists.

## Test plan
- **Standard vector.** `key_in`=0123456789abcdeffedcba9876543210, start → rk[0]=f12186f9 one cycle after accept, and rk[31]=9124a012 with `done_out`=1 in the same cycle. Exactly 32 `rk_valid_out` pulses occur.
- **CK check.** Probe `ck_parameter_in` over a run → the sequence starts 00070e15, 1c232a31 and ends 646b7279 at `rnd`=31.
- **Start while busy and back-to-back.** `start_in` pulse at round 10 → ignored, and the key stream is unchanged. `start_in` in the `done_out` cycle with a new key → the second run's rk[0] appears one cycle later, with no idle gap.
- **Abort.**
  - `abort_in` at `rnd`=5 → `busy_out`=0 next cycle, no further `rk_valid_out`, no `done_out`.
  - `abort_in` coincident with `rnd`=31 → no `done_out`.
  - A subsequent start reproduces rk[0]=f12186f9.
- **Reset mid-run.** `rst` at `rnd`=17 → all outputs 0 next cycle and the FSM is in IDLE. A fresh start behaves as in the standard-vector scenario.
- **`KEY_EXP_STORE_EN` build.**
  - After done, read addr 0 → f12186f9 one cycle later; addr 31 → 9124a012.
  - `rk_table_valid_out` drops on the next start accept.
